// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the cache-to-memory request protocol.
//   word_t      : one machine word (address or data)
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : memory arbiter state encoding; the bench uses it to decode
//                 the arbiter state register
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREAD  = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: responder side of the cache-to-memory request protocol.
// Arbitrates the instruction requester (icache) and the data requester
// (dcache) onto one shared RAM port. Completion is reported through the
// wait/load handshake.
//
// Ports:
//   CLK, RST                 clock and asynchronous active-high reset
//   iREN, iaddr              instruction read request and address
//   iwait, iload             low for one cycle with the instruction word valid
//   dREN, dWEN, daddr, dstore data read or write request, address, write data
//   dwait, dload             low for one cycle at data completion, read data
//   ramREN, ramWEN           RAM read and write strobes
//   ramaddr, ramstore        RAM address and write data
//   ramload, ramstate        RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  ramstate_t        ram_st;
  logic             data_grant;

  assign ram_st = ramstate_t'(ramstate);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Grant decision in IDLE, and strobes/completion in the active states.
  // A completion is reported only while the owner still holds its request,
  // so a withdrawn request never sees wait drop. ERROR simply holds the
  // state with strobes asserted, which retries the access.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    data_grant   = 1'b0;
    iwait        = 1'b1;
    iload        = '0;
    dwait        = 1'b1;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    case (state_q)
      IDLE: begin
        if (iREN && (starve_cnt_q == CNT_MAX)) begin
          state_d      = IREAD;
          starve_cnt_d = '0;
        end else if (dWEN) begin
          state_d    = DWRITE;
          data_grant = 1'b1;
        end else if (dREN) begin
          state_d    = DREAD;
          data_grant = 1'b1;
        end else if (iREN) begin
          state_d      = IREAD;
          starve_cnt_d = '0;
        end
        // Data grants only count toward starvation while iREN is waiting.
        if (data_grant) begin
          if (!iREN) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      IREAD: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_st == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end

      DREAD: begin
        ramREN  = dREN;
        ramaddr = daddr;
        if (!dREN) begin
          state_d = IDLE;
        end else if (ram_st == ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end
      end

      DWRITE: begin
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dWEN) begin
          state_d = IDLE;
        end else if (ram_st == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: reset, instruction read, data write,
// request priority, starvation limit, withdrawal, ERROR retry and
// mid-transaction reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int compared;
  int mismatched;

  memory_arbiter #(.STARVE_MAX(4), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change 1 time unit after the rising edge; checks follow 2 units
  // later, well away from both clock edges.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    #1;
    RST = 1'b1;
    #2;
    compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, IDLE); end
    compared++; if (iwait !== 1'b1) begin mismatched++; $display("FAIL rst_iwait: got %0h expected 1", iwait); end
    compared++; if (dwait !== 1'b1) begin mismatched++; $display("FAIL rst_dwait: got %0h expected 1", dwait); end
    compared++; if (ramaddr !== 32'h0) begin mismatched++; $display("FAIL rst_ramaddr: got %0h expected 0", ramaddr); end
    // Requests and ACCESS during reset must not leak onto the outputs.
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h77;
    ramstate = 2'd2; ramload = 32'hFFFF_0000;
    next_cycle();
    #2;
    compared++; if (iwait !== 1'b1) begin mismatched++; $display("FAIL rst_hold_iwait: got %0h expected 1", iwait); end
    compared++; if (dwait !== 1'b1) begin mismatched++; $display("FAIL rst_hold_dwait: got %0h expected 1", dwait); end
    compared++; if (iload !== 32'h0) begin mismatched++; $display("FAIL rst_hold_iload: got %0h expected 0", iload); end
    compared++; if (dload !== 32'h0) begin mismatched++; $display("FAIL rst_hold_dload: got %0h expected 0", dload); end
    compared++; if ({ramREN, ramWEN} !== 2'b00) begin mismatched++; $display("FAIL rst_hold_strobes: got %0b expected 00", {ramREN, ramWEN}); end
    compared++; if (ramstore !== 32'h0) begin mismatched++; $display("FAIL rst_hold_ramstore: got %0h expected 0", ramstore); end
    next_cycle();
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramstate = 2'd0; ramload = '0;
  endtask

  task automatic test_iread();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
    #2;
    compared++; if (ramREN !== 1'b0) begin mismatched++; $display("FAIL ird_c0_ramREN: got %0h expected 0", ramREN); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      #2;
      compared++; if (dut.state_q !== IREAD) begin mismatched++; $display("FAIL ird_c%0d_state: got %0d expected %0d", c, dut.state_q, IREAD); end
      compared++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin mismatched++; $display("FAIL ird_c%0d_strobe: got ren=%0h addr=%0h expected ren=1 addr=40", c, ramREN, ramaddr); end
      compared++; if (iwait !== 1'b1) begin mismatched++; $display("FAIL ird_c%0d_iwait: got %0h expected 1", c, iwait); end
    end
    next_cycle();
    ramstate = 2'd2; ramload = 32'h8C22_0004;
    #2;
    compared++; if (iwait !== 1'b0) begin mismatched++; $display("FAIL ird_c3_iwait: got %0h expected 0", iwait); end
    compared++; if (iload !== 32'h8C22_0004) begin mismatched++; $display("FAIL ird_c3_iload: got %0h expected 8c220004", iload); end
    compared++; if (dwait !== 1'b1 || dload !== 32'h0) begin mismatched++; $display("FAIL ird_c3_dside: got dwait=%0h dload=%0h expected 1/0", dwait, dload); end
    next_cycle();
    iREN = 1'b0; ramstate = 2'd0;
    #2;
    compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("FAIL ird_c4_state: got %0d expected %0d", dut.state_q, IDLE); end
    compared++; if (iwait !== 1'b1 || iload !== 32'h0) begin mismatched++; $display("FAIL ird_c4_iside: got iwait=%0h iload=%0h expected 1/0", iwait, iload); end
  endtask

  task automatic test_dwrite();
    next_cycle();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = 2'd2; ramload = 32'h1111_2222;
    #2;
    compared++; if (dwait !== 1'b1) begin mismatched++; $display("FAIL dwr_c0_dwait: got %0h expected 1", dwait); end
    next_cycle();
    #2;
    compared++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin mismatched++; $display("FAIL dwr_c1_strobes: got wen=%0h ren=%0h expected 1/0", ramWEN, ramREN); end
    compared++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL dwr_c1_addr_data: got %0h/%0h expected 100/deadbeef", ramaddr, ramstore); end
    compared++; if (dwait !== 1'b0) begin mismatched++; $display("FAIL dwr_c1_dwait: got %0h expected 0", dwait); end
    compared++; if (iwait !== 1'b1) begin mismatched++; $display("FAIL dwr_c1_iwait: got %0h expected 1", iwait); end
    compared++; if (dload !== 32'h0) begin mismatched++; $display("FAIL dwr_c1_dload: got %0h expected 0", dload); end
    next_cycle();
    dWEN = 1'b0; ramstate = 2'd0;
    #2;
    compared++; if (dut.state_q !== IDLE || ramWEN !== 1'b0) begin mismatched++; $display("FAIL dwr_c2_idle: got state=%0d wen=%0h expected %0d/0", dut.state_q, ramWEN, IDLE); end
  endtask

  task automatic test_priority();
    next_cycle();
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h200; daddr = 32'h300; dstore = 32'h1234; ramstate = 2'd2; ramload = 32'hCAFE_0001;
    #2;
    next_cycle();
    #2;
    compared++; if (dut.state_q !== DWRITE) begin mismatched++; $display("FAIL pri_first_state: got %0d expected %0d", dut.state_q, DWRITE); end
    compared++; if (dwait !== 1'b0 || iwait !== 1'b1) begin mismatched++; $display("FAIL pri_first_waits: got d=%0h i=%0h expected 0/1", dwait, iwait); end
    next_cycle();
    dWEN = 1'b0;
    #2;
    compared++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin mismatched++; $display("FAIL pri_gap_strobes: got %0b expected 00", {ramREN, ramWEN}); end
    next_cycle();
    #2;
    compared++; if (dut.state_q !== DREAD) begin mismatched++; $display("FAIL pri_second_state: got %0d expected %0d", dut.state_q, DREAD); end
    compared++; if (ramaddr !== 32'h300 || dload !== 32'hCAFE_0001) begin mismatched++; $display("FAIL pri_second_data: got addr=%0h dload=%0h expected 300/cafe0001", ramaddr, dload); end
    compared++; if (dwait !== 1'b0 || iwait !== 1'b1 || iload !== 32'h0) begin mismatched++; $display("FAIL pri_second_waits: got d=%0h i=%0h iload=%0h expected 0/1/0", dwait, iwait, iload); end
    next_cycle();
    dREN = 1'b0;
    #2;
    next_cycle();
    #2;
    compared++; if (dut.state_q !== IREAD) begin mismatched++; $display("FAIL pri_third_state: got %0d expected %0d", dut.state_q, IREAD); end
    compared++; if (iwait !== 1'b0 || iload !== 32'hCAFE_0001 || ramaddr !== 32'h200) begin mismatched++; $display("FAIL pri_third_iside: got iwait=%0h iload=%0h addr=%0h expected 0/cafe0001/200", iwait, iload, ramaddr); end
    compared++; if (dwait !== 1'b1) begin mismatched++; $display("FAIL pri_third_dwait: got %0h expected 1", dwait); end
    next_cycle();
    iREN = 1'b0; ramstate = 2'd0;
  endtask

  task automatic test_starvation();
    next_cycle();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h480; daddr = 32'h900;
    ramstate = 2'd2; ramload = 32'h0BAD_F00D;
    for (int k = 1; k <= 4; k++) begin
      #2;
      compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("FAIL stv_idle%0d_state: got %0d expected %0d", k, dut.state_q, IDLE); end
      next_cycle();
      #2;
      compared++; if (dut.state_q !== DREAD || dwait !== 1'b0 || iwait !== 1'b1) begin mismatched++; $display("FAIL stv_grant%0d: got state=%0d dwait=%0h iwait=%0h expected %0d/0/1", k, dut.state_q, dwait, iwait, DREAD); end
      next_cycle();
    end
    #2;
    next_cycle();
    #2;
    compared++; if (dut.state_q !== IREAD) begin mismatched++; $display("FAIL stv_grant5_state: got %0d expected %0d", dut.state_q, IREAD); end
    compared++; if (iwait !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h480) begin mismatched++; $display("FAIL stv_grant5_waits: got i=%0h d=%0h addr=%0h expected 0/1/480", iwait, dwait, ramaddr); end
    next_cycle();
    iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
    #2;
  endtask

  task automatic test_withdraw();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h80; ramstate = 2'd1;
    next_cycle();
    #2;
    compared++; if (ramREN !== 1'b1) begin mismatched++; $display("FAIL wdr_c1_ramREN: got %0h expected 1", ramREN); end
    next_cycle();
    iREN = 1'b0; ramstate = 2'd2; ramload = 32'h7777_7777;
    #2;
    compared++; if (ramREN !== 1'b0) begin mismatched++; $display("FAIL wdr_c2_ramREN: got %0h expected 0", ramREN); end
    compared++; if (iwait !== 1'b1 || iload !== 32'h0) begin mismatched++; $display("FAIL wdr_c2_iside: got iwait=%0h iload=%0h expected 1/0", iwait, iload); end
    next_cycle();
    #2;
    compared++; if (dut.state_q !== IDLE || iwait !== 1'b1) begin mismatched++; $display("FAIL wdr_c3: got state=%0d iwait=%0h expected %0d/1", dut.state_q, iwait, IDLE); end
    ramstate = 2'd0;
  endtask

  task automatic test_error();
    next_cycle();
    dREN = 1'b1; daddr = 32'h500; ramstate = 2'd3; ramload = 32'h55AA_55AA;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      #2;
      compared++; if (dwait !== 1'b1 || ramREN !== 1'b1 || dut.state_q !== DREAD) begin mismatched++; $display("FAIL err_c%0d: got dwait=%0h ren=%0h state=%0d expected 1/1/%0d", c, dwait, ramREN, dut.state_q, DREAD); end
    end
    next_cycle();
    ramstate = 2'd2;
    #2;
    compared++; if (dwait !== 1'b0 || dload !== 32'h55AA_55AA) begin mismatched++; $display("FAIL err_access: got dwait=%0h dload=%0h expected 0/55aa55aa", dwait, dload); end
    next_cycle();
    dREN = 1'b0; ramstate = 2'd0;
    #2;
    compared++; if (dut.state_q !== IDLE || dwait !== 1'b1) begin mismatched++; $display("FAIL err_after: got state=%0d dwait=%0h expected %0d/1", dut.state_q, dwait, IDLE); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    dREN = 1'b1; daddr = 32'h600; ramstate = 2'd1; ramload = 32'h9999_0000;
    next_cycle();
    #2;
    compared++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin mismatched++; $display("FAIL rmid_active: got ren=%0h addr=%0h expected 1/600", ramREN, ramaddr); end
    next_cycle();
    RST = 1'b1; ramstate = 2'd2;
    #2;
    compared++; if (dut.state_q !== IDLE) begin mismatched++; $display("FAIL rmid_state: got %0d expected %0d", dut.state_q, IDLE); end
    compared++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin mismatched++; $display("FAIL rmid_ram: got ren=%0h addr=%0h expected 0/0", ramREN, ramaddr); end
    compared++; if (dwait !== 1'b1 || dload !== 32'h0) begin mismatched++; $display("FAIL rmid_dside: got dwait=%0h dload=%0h expected 1/0", dwait, dload); end
    next_cycle();
    RST = 1'b0;
    #2;
    compared++; if (dut.state_q !== IDLE || ramREN !== 1'b0) begin mismatched++; $display("FAIL rmid_restart_idle: got state=%0d ren=%0h expected %0d/0", dut.state_q, ramREN, IDLE); end
    next_cycle();
    #2;
    compared++; if (dwait !== 1'b0 || dload !== 32'h9999_0000 || ramaddr !== 32'h600) begin mismatched++; $display("FAIL rmid_restart_done: got dwait=%0h dload=%0h addr=%0h expected 0/99990000/600", dwait, dload, ramaddr); end
    next_cycle();
    dREN = 1'b0; ramstate = 2'd0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_iread();
    test_dwrite();
    test_priority();
    test_starvation();
    test_withdraw();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
